// File: rtl/fp_simd_arbiter.sv
// fp_simd_arbiter: round-robin owner of one shared 4-lane FP SIMD ALU.
// Latches the winner's opcode/operands, issues a single-cycle enable, waits
// for the result (or times out) and acks the owner. A lock keeps ownership
// across consecutive ops so load/reduce sequences are not interleaved.
module fp_simd_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 88,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_lock,
  input  logic [3*N_REQ-1:0]      i_opcode,
  input  logic [DATA_W*N_REQ-1:0] i_in1,
  input  logic [DATA_W*N_REQ-1:0] i_in2,
  output logic [N_REQ-1:0]        o_accept,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_ack,
  output logic                    o_err,
  output logic [DATA_W-1:0]       o_result,
  output logic                    o_simd_en,
  output logic [2:0]              o_simd_opcode,
  output logic [DATA_W-1:0]       o_simd_in1,
  output logic [DATA_W-1:0]       o_simd_in2,
  input  logic [DATA_W-1:0]       i_simd_output,
  input  logic                    i_simd_busy,
  input  logic                    i_simd_valid
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t             state_q, state_nxt;
  logic [IDX_W-1:0]   owner_q, rr_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [2:0]         op_q;
  logic [DATA_W-1:0]  in1_q, in2_q, result_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx, probe, acc_idx;
  logic               acc_fire, is_load;

  // Requester index after k, wrapping at N_REQ (N_REQ need not be a power of 2)
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
    if (int'(k) == N_REQ - 1) return '0;
    else return k + IDX_W'(1);
  endfunction

  // Round-robin search: first requester at or after the pointer, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    probe     = rr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && i_req[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
      probe = next_idx(probe);
    end
  end

  // Inside a lock only the owner can transfer; otherwise the round-robin winner
  assign acc_idx  = (state_q == S_HOLD) ? owner_q : win_idx;
  assign acc_fire = |(i_req & o_accept);
  // Opcodes 110/111 load the ALU's internal register and never report busy/valid
  assign is_load  = (op_q[2:1] == 2'b11);

  // Next-state and per-state handshake outputs
  always_comb begin
    state_nxt = state_q;
    o_accept  = '0;
    o_simd_en = 1'b0;
    o_ack     = '0;
    o_err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          o_accept  = N_REQ'(1) << win_idx;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!i_simd_busy) begin
          o_simd_en = 1'b1;
          state_nxt = is_load ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_simd_valid || cnt_q == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        o_ack     = gnt_q;
        o_err     = err_q;
        state_nxt = i_lock[owner_q] ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        o_accept = gnt_q & i_req;
        if (i_req[owner_q])       state_nxt = S_ISSUE;
        else if (!i_lock[owner_q]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, ownership, latched operands, result capture and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_q     <= '0;
      op_q     <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_nxt;
      if (acc_fire) begin
        op_q    <= i_opcode[3*int'(acc_idx) +: 3];
        in1_q   <= i_in1[DATA_W*int'(acc_idx) +: DATA_W];
        in2_q   <= i_in2[DATA_W*int'(acc_idx) +: DATA_W];
        owner_q <= acc_idx;
        gnt_q   <= N_REQ'(1) << acc_idx;
      end
      case (state_q)
        S_ISSUE: begin
          if (!i_simd_busy) begin
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (i_simd_valid) begin
            result_q <= i_simd_output;
          end else if (cnt_q == CNT_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end
        end
        S_DONE: begin
          if (!i_lock[owner_q]) begin
            gnt_q <= '0;
            rr_q  <= next_idx(owner_q);
          end
        end
        S_HOLD: begin
          if (!i_req[owner_q] && !i_lock[owner_q]) begin
            gnt_q <= '0;
            rr_q  <= next_idx(owner_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_gnt         = gnt_q;
  assign o_result      = result_q;
  assign o_simd_opcode = op_q;
  assign o_simd_in1    = in1_q;
  assign o_simd_in2    = in2_q;

endmodule

// File: tb/tb_fp_simd_arbiter.sv
// tb_fp_simd_arbiter: directed scoreboard bench for fp_simd_arbiter with a
// behavioural ALU model (result = in1 + in2 + opcode, latency by opcode).
module tb_fp_simd_arbiter;

  localparam int N  = 4;
  localparam int DW = 88;
  localparam int ORD2 [5] = '{0, 1, 2, 3, 0};
  localparam int ORD3 [4] = '{1, 1, 2, 0};
  localparam int ORD6 [2] = '{0, 2};

  typedef struct {
    int            k;
    logic [DW-1:0] res;
    logic          chk_res;
    logic          err;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          req_b  [N];
  logic          lock_b [N];
  logic [2:0]    op_b   [N];
  logic [DW-1:0] a_b    [N];
  logic [DW-1:0] b_b    [N];

  logic [N-1:0]    req_v, lock_v;
  logic [3*N-1:0]  op_v;
  logic [DW*N-1:0] in1_v, in2_v;

  logic [N-1:0]  o_accept, o_gnt, o_ack;
  logic          o_err, o_simd_en;
  logic [DW-1:0] o_result, o_simd_in1, o_simd_in2;
  logic [2:0]    o_simd_opcode;
  logic [DW-1:0] alu_out;
  logic          alu_busy, alu_valid, alu_mute;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic pending;
  int   lock_drop;
  exp_t sb [$];
  int   acc_log [$];
  int   acc_cyc [$];

  fp_simd_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(req_v), .i_lock(lock_v), .i_opcode(op_v), .i_in1(in1_v), .i_in2(in2_v),
    .o_accept(o_accept), .o_gnt(o_gnt), .o_ack(o_ack), .o_err(o_err), .o_result(o_result),
    .o_simd_en(o_simd_en), .o_simd_opcode(o_simd_opcode), .o_simd_in1(o_simd_in1),
    .o_simd_in2(o_simd_in2), .i_simd_output(alu_out), .i_simd_busy(alu_busy),
    .i_simd_valid(alu_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_v = '0; lock_v = '0; op_v = '0; in1_v = '0; in2_v = '0;
    for (int k = 0; k < N; k++) begin
      req_v[k]           = req_b[k];
      lock_v[k]          = lock_b[k];
      op_v[3*k +: 3]     = op_b[k];
      in1_v[DW*k +: DW]  = a_b[k];
      in2_v[DW*k +: DW]  = b_b[k];
    end
  end

  function automatic int alu_lat(input logic [2:0] op);
    case (op)
      3'b011:  return 3;
      3'b101:  return 8;
      default: return 4;
    endcase
  endfunction

  task automatic chk_int(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Raise a request, wait for its transfer edge, queue the expected ack, drop it
  task automatic do_op(input int k, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic lk, input logic [DW-1:0] er,
                       input logic cr, input logic ee, input int lat, input int stall);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    op_b[k] = op; a_b[k] = a; b_b[k] = b; lock_b[k] = lk; req_b[k] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_accept[k] && n < 300);
    if (!o_accept[k]) begin
      total++; bad++;
      $display("FAIL accept_timeout: req%0d never accepted, required accept", k);
      req_b[k] = 1'b0;
      return;
    end
    e.k = k; e.res = er; e.chk_res = cr; e.err = ee; e.cyc = cyc + lat + 2 + stall;
    sb.push_back(e);
    acc_log.push_back(k);
    acc_cyc.push_back(cyc);
    @(posedge clk); #1;
    req_b[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pending || sb.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (pending || sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending=%0b outstanding=%0d, required 0", pending, sb.size());
      sb.delete();
      pending = 1'b0;
    end
  endtask

  task automatic chk_order(input string name, input int idx, input int exp);
    if (idx < acc_log.size()) chk_int(name, acc_log[idx], exp);
    else chk_int(name, -1, exp);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      req_b[k] = 1'b0; lock_b[k] = 1'b0; op_b[k] = '0; a_b[k] = '0; b_b[k] = '0;
    end
    alu_busy = 1'b0; alu_valid = 1'b0; alu_out = '0; alu_mute = 1'b0;
    pending = 1'b0; lock_drop = 0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            chk_int("gnt_onehot0", int'($onehot0(o_gnt)), 1);
            if (o_err && o_ack == '0) begin
              total++; bad++;
              $display("FAIL err_without_ack: o_err=1 o_ack=%b, required an ack pulse", o_ack);
            end
            if (o_ack != '0) begin
              if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ack: o_ack=%b, required no ack", o_ack);
              end else begin
                e = sb.pop_front();
                chk_int("ack_owner", int'(o_ack), 1 << e.k);
                chk_int("ack_err", int'(o_err), int'(e.err));
                chk_int("ack_cycle", cyc, e.cyc);
                if (e.chk_res) chk_vec("ack_result", o_result, e.res);
              end
              pending = 1'b0;
            end
            if ((o_accept & req_v) != '0) begin
              if (pending) begin
                total++; bad++;
                $display("FAIL accept_before_ack: accept=%b while op outstanding, required none", o_accept);
              end
              pending = 1'b1;
            end
          end
        end
      end
      begin : alu_model
        int            lat;
        logic [DW-1:0] r;
        forever begin
          @(negedge clk);
          if (rst_n && o_simd_en && o_simd_opcode[2:1] != 2'b11 && !alu_mute) begin
            lat = alu_lat(o_simd_opcode);
            r   = o_simd_in1 + o_simd_in2 + {{(DW-3){1'b0}}, o_simd_opcode};
            repeat (lat) @(posedge clk);
            #1;
            alu_valid = 1'b1;
            alu_out   = r;
            @(posedge clk); #1;
            alu_valid = 1'b0;
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk_int("rst_gnt", int'(o_gnt), 0);
    chk_int("rst_ack", int'(o_ack), 0);
    chk_int("rst_err", int'(o_err), 0);
    chk_int("rst_en", int'(o_simd_en), 0);
    chk_int("rst_opcode", int'(o_simd_opcode), 0);
    chk_vec("rst_result", o_result, '0);
    rst_n = 1'b1;

    // Single op: add 1+1 on requester 0
    acc_log.delete(); acc_cyc.delete();
    do_op(0, 3'b000, 88'h1, 88'h1, 1'b0, 88'h2, 1'b1, 1'b0, 4, 0);
    @(negedge clk);
    chk_int("t1_simd_en", int'(o_simd_en), 1);
    chk_vec("t1_simd_in1", o_simd_in1, 88'h1);
    wait_idle();
    @(negedge clk);
    chk_int("t1_gnt_release", int'(o_gnt), 0);

    // Round robin: requester 0 first, then 1,2,3 join and 0 comes back
    acc_log.delete(); acc_cyc.delete();
    fork
      begin
        do_op(0, 3'b000, 88'h10, 88'h1, 1'b0, 88'h11, 1'b1, 1'b0, 4, 0);
        do_op(0, 3'b001, 88'h100, 88'h5, 1'b0, 88'h106, 1'b1, 1'b0, 4, 0);
      end
      begin @(posedge clk); do_op(1, 3'b011, 88'h20, 88'h2, 1'b0, 88'h25, 1'b1, 1'b0, 3, 0); end
      begin @(posedge clk); do_op(2, 3'b010, 88'h30, 88'h3, 1'b0, 88'h35, 1'b1, 1'b0, 4, 0); end
      begin @(posedge clk); do_op(3, 3'b000, 88'h40, 88'h4, 1'b0, 88'h44, 1'b1, 1'b0, 4, 0); end
    join
    wait_idle();
    for (int i = 0; i < 5; i++) chk_order("t2_order", i, ORD2[i]);

    // Lock: requester 1 loads then reduces while 2 and 0 wait
    acc_log.delete(); acc_cyc.delete();
    fork
      begin
        int n1;
        do_op(1, 3'b110, 88'hABC, 88'h0, 1'b1, 88'h0, 1'b0, 1'b0, 0, 0);
        do_op(1, 3'b101, 88'h7, 88'h8, 1'b1, 88'h14, 1'b1, 1'b0, 8, 0);
        n1 = 0;
        while (!o_ack[1] && n1 < 100) begin @(negedge clk); n1++; end
        repeat (3) @(posedge clk);
        #1;
        lock_b[1] = 1'b0;
        lock_drop = cyc;
      end
      begin repeat (2) @(posedge clk); do_op(2, 3'b000, 88'h1000, 88'h234, 1'b0, 88'h1234, 1'b1, 1'b0, 4, 0); end
      begin repeat (2) @(posedge clk); do_op(0, 3'b100, 88'h40, 88'h4, 1'b0, 88'h48, 1'b1, 1'b0, 4, 0); end
    join
    wait_idle();
    for (int i = 0; i < 4; i++) chk_order("t3_order", i, ORD3[i]);
    if (acc_cyc.size() > 2) chk_int("t3_release_accept", acc_cyc[2], lock_drop + 1);
    else chk_int("t3_release_accept", -1, lock_drop + 1);

    // Timeout: ALU never answers
    alu_mute = 1'b1;
    do_op(2, 3'b000, 88'h55, 88'h66, 1'b0, 88'h0, 1'b1, 1'b1, 16, 0);
    wait_idle();
    @(negedge clk);
    chk_int("t5_gnt_idle", int'(o_gnt), 0);
    alu_mute = 1'b0;

    // Busy stall: enable delayed 3 cycles, operands held
    alu_busy = 1'b1;
    do_op(0, 3'b010, 88'h9, 88'h7, 1'b0, 88'h12, 1'b1, 1'b0, 4, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_int("t4_en_stalled", int'(o_simd_en), 0);
      chk_int("t4_opcode_hold", int'(o_simd_opcode), 2);
      chk_vec("t4_in1_hold", o_simd_in1, 88'h9);
      chk_vec("t4_in2_hold", o_simd_in2, 88'h7);
    end
    @(posedge clk); #1;
    alu_busy = 1'b0;
    @(negedge clk);
    chk_int("t4_en_release", int'(o_simd_en), 1);
    wait_idle();

    // Reset in the middle of WAIT, then pointer restarts at 0
    alu_mute = 1'b1;
    begin
      int n6;
      @(posedge clk); #1;
      op_b[3] = 3'b001; a_b[3] = 88'hAA; b_b[3] = 88'hBB; req_b[3] = 1'b1;
      n6 = 0;
      do begin @(negedge clk); n6++; end while (!o_accept[3] && n6 < 50);
      chk_int("t6_accept3", int'(o_accept[3]), 1);
      @(posedge clk); #1;
      req_b[3] = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_int("t6_rst_gnt", int'(o_gnt), 0);
    chk_int("t6_rst_en", int'(o_simd_en), 0);
    chk_int("t6_rst_ack", int'(o_ack), 0);
    chk_int("t6_rst_err", int'(o_err), 0);
    chk_int("t6_rst_opcode", int'(o_simd_opcode), 0);
    chk_vec("t6_rst_in1", o_simd_in1, '0);
    chk_vec("t6_rst_in2", o_simd_in2, '0);
    chk_vec("t6_rst_result", o_result, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pending = 1'b0;
    alu_mute = 1'b0;
    acc_log.delete(); acc_cyc.delete();
    fork
      do_op(0, 3'b000, 88'h3, 88'h4, 1'b0, 88'h7, 1'b1, 1'b0, 4, 0);
      do_op(2, 3'b000, 88'h5, 88'h6, 1'b0, 88'hB, 1'b1, 1'b0, 4, 0);
    join
    wait_idle();
    for (int i = 0; i < 2; i++) chk_order("t6_order", i, ORD6[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_simd_arbiter.md
Name: fp_simd_arbiter

Overview:
- Shares one 4-lane FP SIMD ALU (22-bit lanes, 88-bit vectors) between N_REQ requesters, e.g. vertex transform, rasteriser setup and shading.
- Round-robin grant; latches opcode and operands; drives the ALU enable for one cycle and holds its opcode and inputs stable for the whole operation; returns the result to the winner.
- A lock lets one requester run load then reduce sequences without another requester corrupting the ALU's internal register.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 88, vector width (4 lanes x 22 bits)
- TIMEOUT_CYC, 16, max cycles in WAIT before an error abort

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  N_REQ  per-requester op valid, level
- i_lock  in  N_REQ  keep grant after this op completes
- i_opcode  in  3*N_REQ  requester k uses bits [3k+2:3k]
- i_in1  in  DATA_W*N_REQ  requester k operand 1, slice k
- i_in2  in  DATA_W*N_REQ  requester k operand 2, slice k
- o_accept  out  N_REQ  combinational ready; op transfers on the edge where i_req[k] and o_accept[k] are both high
- o_gnt  out  N_REQ  one-hot current owner, registered
- o_ack  out  N_REQ  1-cycle completion pulse to the owner
- o_err  out  1  1-cycle pulse with o_ack on timeout
- o_result  out  DATA_W  result, valid in the o_ack cycle, held until the next ack
- o_simd_en  out  1  ALU enable
- o_simd_opcode  out  3  latched opcode
- o_simd_in1  out  DATA_W  latched operand 1
- o_simd_in2  out  DATA_W  latched operand 2
- i_simd_output  in  DATA_W  ALU result
- i_simd_busy  in  1  ALU busy
- i_simd_valid  in  1  ALU result valid (1 cycle)

Behaviour:
- Reset values:
  - State IDLE; o_gnt, o_ack, o_err, o_simd_en all 0.
  - o_result, latched opcode and operands all 0; rr pointer 0; timeout counter 0.
- States: IDLE, ISSUE, WAIT, DONE, HOLD.
- IDLE:
  - Winner = first k with i_req[k]=1, searching from the rr pointer upward and wrapping mod N_REQ.
  - o_accept[winner]=1, all other bits 0.
  - On that edge: latch i_opcode/i_in1/i_in2 slice k, set o_gnt to one-hot k, go to ISSUE.
  - No requests: stay IDLE.
- ISSUE:
  - o_simd_en=1 only while i_simd_busy=0; otherwise stay in ISSUE with o_simd_en=0.
  - On the enable edge: opcode 110/111 (register loads, no busy/valid from the ALU) go to DONE; all other opcodes go to WAIT and clear the timeout counter.
- WAIT:
  - o_simd_en=0; the counter increments each cycle.
  - i_simd_valid=1: capture i_simd_output into o_result, go to DONE.
  - Counter reaches TIMEOUT_CYC-1 with no valid: o_result=0, flag error, go to DONE.
- DONE (one cycle):
  - o_ack[owner]=1; o_err=1 if flagged.
  - If i_lock[owner]=1: go to HOLD, grant kept.
  - Otherwise: clear o_gnt, set rr pointer = owner+1 mod N_REQ, go to IDLE.
- HOLD:
  - Only the owner can be accepted: o_accept[owner]=i_req[owner]; it latches and goes to ISSUE.
  - If i_lock[owner]=0 and i_req[owner]=0: release (pointer = owner+1), go to IDLE.
  - Other requests wait, with no starvation limit inside a lock.
- o_simd_opcode/in1/in2 hold the latched values from ISSUE through DONE; they change only on the next accept.
- ALU latencies (en edge to valid): add/sub/mul 4, rcp 3, reduce 8.
  - Total turnaround from accept edge to ack is ALU latency + 2 cycles.
  - Loads: ack 2 cycles after accept.
- Simultaneous events:
  - A requester dropping i_req in the accept cycle has no effect; the transfer is defined by the edge sample.
  - i_simd_valid outside WAIT is ignored.
  - A lock change during ISSUE/WAIT matters only when sampled in DONE.
- Reset mid-operation: immediate return to reset values. Because the ALU shares rst_n, no stale valid is expected.

Test Plan:
1. Single op: req0 with opcode 000, in1=in2=88'h1, ALU model latency 4 -> o_accept[0] at t0, o_simd_en at t1, o_ack[0] at t6, o_result equals the model output; o_gnt returns to 0 at t7.
2. Round robin: req0..3 held continuously with add ops -> grant order 0,1,2,3,0; each ack precedes the next accept; o_gnt is always one-hot or zero.
3. Lock sequence: req1 with lock=1 issues 110 then 101 while req2 is pending -> ack for the load 2 cycles after accept, reduce ack 10 cycles after its accept; req2 accepted only after lock drops and HOLD releases; pointer = 2.
4. Busy stall: i_simd_busy forced high for 3 cycles during ISSUE -> o_simd_en is delayed 3 cycles; opcode and operands stay stable throughout.
5. Timeout: model never raises valid -> o_ack and o_err in the same cycle, 16 cycles after the WAIT entry edge; o_result=0; arbiter returns to IDLE.
6. Reset mid-WAIT: rst_n low for 1 cycle -> all outputs 0 immediately; the next request is served starting from pointer 0.
